// File: rtl/sd_resp_pkg.sv
// Shared constants, state type and helpers for the SD block responder.
package sd_resp_pkg;

  localparam int unsigned BLOCK_BYTES = 512;
  localparam int unsigned BLOCK_SHIFT = 9;

  typedef enum logic [2:0] {
    StIdle,
    StRdStart,
    StRdStream,
    StRdTail,
    StWrStart,
    StWrStream,
    StWrBusy
  } sd_resp_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sd_resp_ram.sv
// Single-port byte RAM with registered read and synchronous write; maps onto block RAM.
module sd_resp_ram #(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sd_block_responder.sv
// Block-RAM backed stand-in for the SD controller byte-stream interface.
// Define SD_BLOCK_RESPONDER_STATS_EN to add rd_blocks/wr_blocks completion counters.
module sd_block_responder
  import sd_resp_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 16,
  parameter int unsigned START_LAT  = 8,
  parameter int unsigned BYTE_GAP   = 4,
  parameter int unsigned BUSY_LAT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] address,
  input  logic [7:0]  din,
  output logic        ready,
  output logic [7:0]  dout,
  output logic        byte_available,
  output logic        ready_for_next_byte,
  output logic        addr_err
`ifdef SD_BLOCK_RESPONDER_STATS_EN
  ,
  output logic [15:0] rd_blocks,
  output logic [15:0] wr_blocks
`endif
);

  localparam int unsigned BlkW  = $clog2(NUM_BLOCKS);
  localparam int unsigned RamAw = BlkW + BLOCK_SHIFT;
  localparam int unsigned HiW   = 32 - BLOCK_SHIFT;
  localparam int unsigned CntW  = $clog2(max3(START_LAT, BYTE_GAP, BUSY_LAT)) + 1;

  localparam logic [CntW-1:0] StartLd = CntW'(START_LAT - 1);
  localparam logic [CntW-1:0] GapLd   = CntW'(BYTE_GAP - 1);
  localparam logic [CntW-1:0] TailLd  = CntW'(BYTE_GAP - 2);
  localparam logic [CntW-1:0] BusyLd  = CntW'(BUSY_LAT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [8:0]      LastIdx = 9'(BLOCK_BYTES - 1);

  sd_resp_state_t   state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [8:0]       idx_q, idx_d;
  logic [BlkW-1:0]  blk_q, blk_d;
  logic [7:0]       dout_q, dout_d;
  logic             ba_q, ba_d;
  logic             rfnb_q, rfnb_d;
  logic             err_q, err_d;
  logic             ram_we;
  logic [RamAw-1:0] ram_addr;
  logic [7:0]       ram_rdata;
  logic             addr_bad;

  assign addr_bad = (address[BLOCK_SHIFT-1:0] != '0) ||
                    (address[31:BLOCK_SHIFT] >= HiW'(NUM_BLOCKS));

  sd_resp_ram #(
    .ADDR_W(RamAw)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(din),
    .rdata(ram_rdata)
  );

  // cnt_q counts down to the byte event at zero; registered outputs are staged at one,
  // and the RAM address is settled at least one cycle before that.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    idx_d    = idx_q;
    blk_d    = blk_q;
    dout_d   = dout_q;
    ba_d     = 1'b0;
    rfnb_d   = 1'b0;
    err_d    = 1'b0;
    ram_we   = 1'b0;
    ram_addr = {blk_q, idx_q};
    unique case (state_q)
      StIdle: begin
        // Lets a START_LAT of 2 fetch byte 0 in the acceptance cycle.
        ram_addr = {address[BLOCK_SHIFT +: BlkW], {BLOCK_SHIFT{1'b0}}};
        if (rd || wr) begin
          if (addr_bad) begin
            err_d = 1'b1;
          end else begin
            blk_d   = address[BLOCK_SHIFT +: BlkW];
            idx_d   = '0;
            cnt_d   = StartLd;
            state_d = rd ? StRdStart : StWrStart;
          end
        end
      end
      StRdStart, StRdStream: begin
        if (cnt_q == CntOne) begin
          ba_d   = 1'b1;
          dout_d = ram_rdata;
        end
        if (cnt_q == '0) begin
          if (idx_q == LastIdx) begin
            state_d = StRdTail;
            cnt_d   = TailLd;
          end else begin
            idx_d   = idx_q + 9'd1;
            cnt_d   = GapLd;
            state_d = StRdStream;
          end
        end
      end
      StRdTail: begin
        if (cnt_q == '0) state_d = StIdle;
      end
      StWrStart: begin
        if (cnt_q == CntOne) rfnb_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = StWrStream;
          cnt_d   = GapLd;
        end
      end
      StWrStream: begin
        if (cnt_q == CntOne) begin
          ram_we = 1'b1;
          if (idx_q == LastIdx) begin
            state_d = StWrBusy;
            cnt_d   = BusyLd;
          end else begin
            idx_d  = idx_q + 9'd1;
            rfnb_d = 1'b1;
          end
        end
        if (cnt_q == '0) cnt_d = GapLd;
      end
      StWrBusy: begin
        if (cnt_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      dout_q  <= '0;
      ba_q    <= 1'b0;
      rfnb_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      dout_q  <= dout_d;
      ba_q    <= ba_d;
      rfnb_q  <= rfnb_d;
      err_q   <= err_d;
    end
  end

  assign ready               = (state_q == StIdle);
  assign dout                = dout_q;
  assign byte_available      = ba_q;
  assign ready_for_next_byte = rfnb_q;
  assign addr_err            = err_q;

`ifdef SD_BLOCK_RESPONDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_blocks <= '0;
      wr_blocks <= '0;
    end else begin
      if (state_q == StRdTail && cnt_q == '0) rd_blocks <= rd_blocks + 16'd1;
      if (state_q == StWrBusy && cnt_q == '0) wr_blocks <= wr_blocks + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder: block reads/writes, rejects, abort and stats.
module tb_sd_block_responder;

  localparam int NB   = 16;
  localparam int SL   = 8;
  localparam int GAP  = 4;
  localparam int BUSY = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [31:0] address;
  logic [7:0]  din;
  logic        ready;
  logic [7:0]  dout;
  logic        byte_available;
  logic        ready_for_next_byte;
  logic        addr_err;
`ifdef SD_BLOCK_RESPONDER_STATS_EN
  logic [15:0] rd_blocks;
  logic [15:0] wr_blocks;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [7:0] mem_model [NB*512];

  sd_block_responder dut (
    .clk                (clk),
    .rst                (rst),
    .rd                 (rd),
    .wr                 (wr),
    .address            (address),
    .din                (din),
    .ready              (ready),
    .dout               (dout),
    .byte_available     (byte_available),
    .ready_for_next_byte(ready_for_next_byte),
    .addr_err           (addr_err)
`ifdef SD_BLOCK_RESPONDER_STATS_EN
    ,
    .rd_blocks          (rd_blocks),
    .wr_blocks          (wr_blocks)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input int mode, input int blk, input int k);
    case (mode)
      0:       return 8'(k);
      1:       return 8'(k) ^ 8'hA5;
      2:       return 8'(k * 3 + blk * 17 + 1);
      default: return 8'(k * 5 + blk + 60);
    endcase
  endfunction

  task automatic test_reset();
    @(posedge clk); #1;
    n_chk++;
    if (ready !== 1'b1 || dout !== 8'h00 || byte_available !== 1'b0 ||
        ready_for_next_byte !== 1'b0 || addr_err !== 1'b0)
      $display("FAIL reset_outputs: got rdy=%0b dout=%0h ba=%0b rfnb=%0b err=%0b want 1 0 0 0 0",
               ready, dout, byte_available, ready_for_next_byte, addr_err);
    else n_pass++;
`ifdef SD_BLOCK_RESPONDER_STATS_EN
    n_chk++;
    if (rd_blocks !== 16'd0 || wr_blocks !== 16'd0)
      $display("FAIL reset_stats: got %0d/%0d want 0/0", rd_blocks, wr_blocks);
    else n_pass++;
`endif
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  // Called mid-cycle (after a negedge); that cycle is T. Returns mid-cycle of the ready cycle.
  task automatic do_read(input logic [31:0] a, input int blk, input bit wr_too);
    int t0 = cyc, n = 0, first = -1, last = 0, bad_gap = 0, bad_data = 0, n_rfnb = 0, t_rdy = -1;
    logic [7:0] lastv = 8'h00;
    bit done = 0;
    rd = 1'b1; wr = wr_too; address = a;
    @(posedge clk); #1; rd = 1'b0; wr = 1'b0; address = 32'hDEAD_BE00;
    @(negedge clk);
    n_chk++;
    if (ready !== 1'b0) $display("FAIL rd_ready_low: got %0b want 0", ready); else n_pass++;
    for (int i = 0; i < 2300 && !done; i++) begin
      @(negedge clk);
      if (ready_for_next_byte) n_rfnb++;
      if (byte_available) begin
        if (n == 0) first = cyc; else if (cyc - last != GAP) bad_gap++;
        if (n < 512 && dout !== mem_model[blk*512+n]) bad_data++;
        last = cyc; lastv = dout; n++;
      end else if (n > 0 && dout !== lastv) bad_data++;
      if (ready) begin done = 1; t_rdy = cyc; end
    end
    n_chk++;
    if (first != t0 + SL) $display("FAIL rd_first_byte: got cycle %0d want %0d", first, t0 + SL);
    else n_pass++;
    n_chk++;
    if (n != 512) $display("FAIL rd_byte_count: got %0d want 512", n); else n_pass++;
    n_chk++;
    if (bad_gap != 0) $display("FAIL rd_byte_gap: got %0d bad gaps want 0", bad_gap);
    else n_pass++;
    n_chk++;
    if (bad_data != 0) $display("FAIL rd_data blk%0d: got %0d bad bytes want 0", blk, bad_data);
    else n_pass++;
    n_chk++;
    if (n_rfnb != 0) $display("FAIL rd_no_rfnb: got %0d pulses want 0", n_rfnb); else n_pass++;
    n_chk++;
    if (t_rdy != t0 + SL + 511 * GAP + GAP)
      $display("FAIL rd_ready_return: got cycle %0d want %0d", t_rdy, t0 + SL + 511 * GAP + GAP);
    else n_pass++;
    if (done) exp_rd++;
  endtask

  task automatic do_write(input logic [31:0] a, input int blk, input int mode, input int abort_k);
    int t0 = cyc, n = 0, first = -1, last = 0, bad_gap = 0, n_ba = 0, t_rdy = -1, pend_k = 0;
    bit done = 0, pend = 0, aborted = 0;
    wr = 1'b1; address = a;
    @(posedge clk); #1; wr = 1'b0; address = 32'hDEAD_BE00;
    @(negedge clk);
    n_chk++;
    if (ready !== 1'b0) $display("FAIL wr_ready_low: got %0b want 0", ready); else n_pass++;
    for (int i = 0; i < 2300 && !done && !aborted; i++) begin
      @(posedge clk); #1;
      if (pend) begin din = pat(mode, blk, pend_k); pend = 0; end
      @(negedge clk);
      if (byte_available) n_ba++;
      if (ready_for_next_byte) begin
        if (n == abort_k) begin
          rst = 1'b1; aborted = 1;
        end else begin
          if (n == 0) first = cyc; else if (cyc - last != GAP) bad_gap++;
          if (n < 512) mem_model[blk*512+n] = pat(mode, blk, n);
          last = cyc; pend = 1; pend_k = n; n++;
        end
      end else if (ready) begin
        done = 1; t_rdy = cyc;
      end
    end
    if (abort_k >= 0) begin
      #1;
      n_chk++;
      if (!aborted) $display("FAIL abort_reached: got %0d pulses want %0d", n, abort_k);
      else n_pass++;
      n_chk++;
      if (ready !== 1'b1 || dout !== 8'h00 || byte_available !== 1'b0 ||
          ready_for_next_byte !== 1'b0 || addr_err !== 1'b0)
        $display("FAIL abort_outputs: got rdy=%0b dout=%0h ba=%0b rfnb=%0b err=%0b want 1 0 0 0 0",
                 ready, dout, byte_available, ready_for_next_byte, addr_err);
      else n_pass++;
      @(negedge clk); @(negedge clk); rst = 1'b0;
      exp_rd = 0; exp_wr = 0;
      @(negedge clk);
    end else begin
      n_chk++;
      if (first != t0 + SL) $display("FAIL wr_first_req: got cycle %0d want %0d", first, t0 + SL);
      else n_pass++;
      n_chk++;
      if (n != 512) $display("FAIL wr_req_count: got %0d want 512", n); else n_pass++;
      n_chk++;
      if (bad_gap != 0) $display("FAIL wr_req_gap: got %0d bad gaps want 0", bad_gap);
      else n_pass++;
      n_chk++;
      if (n_ba != 0) $display("FAIL wr_no_ba: got %0d pulses want 0", n_ba); else n_pass++;
      n_chk++;
      if (t_rdy != t0 + SL + 511 * GAP + (GAP - 1) + BUSY + 1)
        $display("FAIL wr_ready_return: got cycle %0d want %0d", t_rdy,
                 t0 + SL + 511 * GAP + (GAP - 1) + BUSY + 1);
      else n_pass++;
      if (done) exp_wr++;
    end
  endtask

  task automatic do_reject(input logic [31:0] a, input bit use_wr);
    int bad = 0;
    rd = !use_wr; wr = use_wr; address = a;
    @(posedge clk); #1; rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    n_chk++;
    if (addr_err !== 1'b1 || ready !== 1'b1)
      $display("FAIL rej_pulse %0h: got err=%0b rdy=%0b want 1 1", a, addr_err, ready);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (addr_err !== 1'b0 || ready !== 1'b1 || byte_available || ready_for_next_byte) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL rej_quiet %0h: got %0d bad cycles want 0", a, bad);
    else n_pass++;
  endtask

  task automatic test_preload();
    do_write(32'h0000_0000, 0, 2, -1);
    do_write(32'h0000_0200, 1, 2, -1);
    do_write(32'h0000_0400, 2, 0, -1);
    do_write(32'h0000_0800, 4, 2, -1);
    do_write(32'h0000_0C00, 6, 2, -1);
  endtask

  task automatic test_read_block2();
    do_read(32'h0000_0400, 2, 1'b0);
  endtask

  task automatic test_write_block5();
    do_write(32'h0000_0A00, 5, 1, -1);
    do_read(32'h0000_0A00, 5, 1'b0);
    do_read(32'h0000_0800, 4, 1'b0);
    do_read(32'h0000_0C00, 6, 1'b0);
  endtask

  task automatic test_addr_err();
    do_reject(32'h0000_0201, 1'b0);
    do_reject(32'h0000_2000, 1'b0);
    do_reject(32'h0000_01FF, 1'b1);
  endtask

  task automatic test_rd_wr_both();
    do_read(32'h0000_0000, 0, 1'b1);
  endtask

  task automatic test_reset_abort();
    do_write(32'h0000_0200, 1, 3, 100);
  endtask

  task automatic test_back_to_back();
    do_read(32'h0000_0200, 1, 1'b0);
    do_write(32'h0000_0E00, 7, 2, -1);
    do_reject(32'h0000_0203, 1'b0);
    do_write(32'h0000_0600, 3, 0, -1);
    do_read(32'h0000_0E00, 7, 1'b0);
    do_read(32'h0000_0600, 3, 1'b0);
`ifdef SD_BLOCK_RESPONDER_STATS_EN
    n_chk++;
    if (rd_blocks !== 16'(exp_rd) || wr_blocks !== 16'(exp_wr) || exp_rd != 3 || exp_wr != 2)
      $display("FAIL stats: got rd=%0d wr=%0d want 3 2", rd_blocks, wr_blocks);
    else n_pass++;
`endif
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; address = 32'h0; din = 8'h00;
    test_reset();
    test_preload();
    test_read_block2();
    test_write_block5();
    test_addr_err();
    test_rd_wr_both();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sd_block_responder.md
Name: sd_block_responder

Overview:
- Responder side of the byte-stream block interface the recorder's store/load logic uses to reach the SD controller (`ready`/`address`/`rd`/`wr`/`dout`/`byte_available`/`din`/`ready_for_next_byte`).
- Serves and accepts 512-byte blocks from on-chip block RAM with SD-like pacing.
- Serves two purposes:
  - drop-in stand-in for the SD controller in simulation;
  - a scratch "RAM disk" for track storage when no card is fitted.

Parameters:
- NUM_BLOCKS, 16, number of 512-byte blocks held (power of two, ≥2).
- START_LAT, 8, cycles from request acceptance to first byte event (≥2).
- BYTE_GAP, 4, cycles between consecutive byte events (≥3).
- BUSY_LAT, 16, cycles of programming busy after the last written byte (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rd  in  1  read-block request, sampled only while ready=1.
- wr  in  1  write-block request, sampled only while ready=1.
- address  in  32  byte address; must be a multiple of 512.
- din  in  8  write byte from initiator.
- ready  out  1  idle, able to accept a request.
- dout  out  8  read byte.
- byte_available  out  1  one-cycle pulse: dout holds a new byte.
- ready_for_next_byte  out  1  one-cycle pulse: initiator must present the next write byte.
- addr_err  out  1  one-cycle pulse: request rejected.

Behaviour:
- Reset values: ready=1, dout=0, byte_available=0, ready_for_next_byte=0, addr_err=0, state=IDLE.
  - RAM contents are not reset.
  - Reset asserted mid-operation aborts at once.
  - Write bytes already committed to RAM persist.
- State machine: IDLE, RD_START, RD_STREAM, RD_TAIL, WR_START, WR_STREAM, WR_BUSY.
- Acceptance (IDLE, cycle T, rd|wr=1):
  - If address[8:0]≠0 or address[31:9]≥NUM_BLOCKS: addr_err=1 at T+1, stay IDLE, ready stays 1.
  - Otherwise ready=0 from T+1.
  - block = address[31:9], latched at T.
  - rd and wr both high: read wins; wr is ignored.
  - address is ignored outside IDLE.
- Read path:
  - Byte k (k=0..511) is presented at cycle T+START_LAT+k·BYTE_GAP.
  - At that cycle dout = RAM[block·512+k] and byte_available=1 for exactly one cycle.
  - dout holds until the next byte.
  - After byte 511: RD_TAIL for BYTE_GAP cycles, then ready=1.
  - Bytes are delivered in ascending order.
  - The RAM read for byte k is issued ahead so the 1-cycle RAM latency is hidden.
- Write path:
  - ready_for_next_byte pulses for one cycle at T+START_LAT+k·BYTE_GAP, requesting byte k.
  - din is sampled BYTE_GAP−1 cycles after pulse k and written to RAM[block·512+k].
  - After byte 511 is sampled: WR_BUSY for BUSY_LAT cycles, then ready=1.
- Byte counter is 9 bits and ends at 511; no wrap into the next block.
- Pacing counter width: $clog2(max(START_LAT, BYTE_GAP, BUSY_LAT))+1.
- Back-to-back requests are allowed: ready=1 and rd=1 in the same cycle starts a new transfer on that cycle.
- byte_available and ready_for_next_byte never assert in IDLE or together.

Optional Feature:
- Macro: SD_BLOCK_RESPONDER_STATS_EN.
- With the macro:
  - Extra outputs rd_blocks[15:0] and wr_blocks[15:0].
  - Each increments (wrapping) by one on completion of a read / write block, at the cycle ready returns to 1.
  - Both reset to 0.
  - Rejected requests are counted in neither.
- Without the macro: outputs and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sd_resp_pkg:
  - BLOCK_BYTES=512 and BLOCK_SHIFT=9;
  - state enum type sd_resp_state_t.
- Sub-module sd_resp_ram:
  - single-port byte RAM, NUM_BLOCKS·512 × 8;
  - 1-cycle registered read, synchronous write, no reset, infers BRAM.

Test Plan:
- Preload block 2 with byte k = k[7:0]; read address 0x400 → exactly 512 byte_available pulses BYTE_GAP apart.
  - First pulse at T+8.
  - dout sequence 0x00..0xFF twice.
  - ready=1 at T+8+511·4+4.
- Write block 5 with din = k^0xA5 (presented the cycle after each ready_for_next_byte) → ready low for 8+511·4+3+16 cycles.
  - Reading back 0xA00 returns 0xA5,0xA4,…
  - Blocks 4 and 6 are unchanged.
- rd at address 0x201 (misaligned) and at 16·512 (out of range) → addr_err one-cycle pulse at T+1, ready stays 1, no byte pulses.
- rd and wr high together at 0x000 → read transfer occurs, no ready_for_next_byte pulses, RAM unchanged.
- Assert rst at byte 100 of a write to block 1 → all outputs return to reset values immediately.
  - Reading block 1 back shows bytes 0..99 new, bytes 100..511 old.
- With SD_BLOCK_RESPONDER_STATS_EN: 3 reads, 2 writes, 1 rejected → rd_blocks=3, wr_blocks=2.
